// File: rtl/fp_stream_source_if.sv
// Control, outgoing/incoming AXI-Stream and status signals of fp_stream_source,
// bundled so the block and its environment connect through one port.
interface fp_stream_source_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    start;

  logic                    m00_axis_tvalid;
  logic [DATA_WIDTH-1:0]   m00_axis_tdata;
  logic [DATA_WIDTH/8-1:0] m00_axis_tstrb;
  logic                    m00_axis_tlast;
  logic                    m00_axis_tready;

  logic                    s00_axis_tready;
  logic [DATA_WIDTH-1:0]   s00_axis_tdata;
  logic                    s00_axis_tlast;
  logic                    s00_axis_tvalid;

  logic                    busy;
  logic                    done;
  logic                    error;
  logic [DATA_WIDTH-1:0]   result;

  // master: the stream source itself; slave: control side plus accelerator.
  modport master (
    input  wr_en, wr_addr, wr_data, start,
    input  m00_axis_tready,
    input  s00_axis_tdata, s00_axis_tlast, s00_axis_tvalid,
    output m00_axis_tvalid, m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast,
    output s00_axis_tready,
    output busy, done, error, result
  );

  modport slave (
    output wr_en, wr_addr, wr_data, start,
    output m00_axis_tready,
    output s00_axis_tdata, s00_axis_tlast, s00_axis_tvalid,
    input  m00_axis_tvalid, m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast,
    input  s00_axis_tready,
    input  busy, done, error, result
  );
endinterface

// File: rtl/fp_stream_source.sv
// Streams a SIZE-word buffer as one AXI-Stream packet, then waits (bounded by
// TIMEOUT cycles) for a single-word result packet and latches it.
module fp_stream_source #(
  parameter int SIZE       = 10,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 1024
) (
  input  logic               s00_axi_aclk,
  input  logic               s00_axi_aresetn,
  fp_stream_source_if.master bus
);

  localparam int          IDX_W  = $clog2(SIZE);
  localparam int          CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [31:0] SIZE_U = SIZE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t                  r_state,    w_state_next;
  logic                    r_tvalid,   w_tvalid_next;
  logic [DATA_WIDTH-1:0]   r_tdata,    w_tdata_next;
  logic                    r_tlast,    w_tlast_next;
  logic                    r_s_tready, w_s_tready_next;
  logic                    r_error,    w_error_next;
  logic [DATA_WIDTH-1:0]   r_result,   w_result_next;
  logic [IDX_W-1:0]        r_idx,      w_idx_next;
  logic [CNT_W-1:0]        r_cnt,      w_cnt_next;

  logic [DATA_WIDTH-1:0]   r_buf [SIZE];

  logic                    w_buf_we;
  logic                    w_addr_ok;
  logic [IDX_W-1:0]        w_idx_inc;
  logic                    w_last_beat;
  logic                    w_timeout;

  assign w_addr_ok   = (32'(bus.wr_addr) < SIZE_U);
  assign w_idx_inc   = r_idx + 1'b1;
  assign w_last_beat = (r_idx == IDX_W'(SIZE - 1));
  assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT - 1));

  // NOTE: the packet buffer carries no reset; its contents are only defined by
  // control-side writes, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge s00_axi_aclk) begin
    if (w_buf_we) begin
      r_buf[bus.wr_addr[IDX_W-1:0]] <= bus.wr_data;
    end
  end

  // NOTE: every output of this process gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_next    = r_state;
    w_tvalid_next   = r_tvalid;
    w_tdata_next    = r_tdata;
    w_tlast_next    = r_tlast;
    w_s_tready_next = r_s_tready;
    w_error_next    = r_error;
    w_result_next   = r_result;
    w_idx_next      = r_idx;
    w_cnt_next      = r_cnt;
    w_buf_we        = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        // A start in the same cycle as a write wins; the write is dropped.
        if (bus.start) begin
          w_state_next  = ST_SEND;
          w_tvalid_next = 1'b1;
          w_tdata_next  = r_buf[0];
          w_tlast_next  = (SIZE == 1);
          w_idx_next    = '0;
          w_error_next  = 1'b0;
        end else if (bus.wr_en && w_addr_ok) begin
          w_buf_we = 1'b1;
        end
      end

      ST_SEND: begin
        if (bus.m00_axis_tready) begin
          if (w_last_beat) begin
            w_state_next    = ST_WAIT;
            w_tvalid_next   = 1'b0;
            w_tlast_next    = 1'b0;
            w_s_tready_next = 1'b1;
            w_cnt_next      = '0;
          end else begin
            w_idx_next   = w_idx_inc;
            w_tdata_next = r_buf[w_idx_inc];
            w_tlast_next = (w_idx_inc == IDX_W'(SIZE - 1));
          end
        end
      end

      ST_WAIT: begin
        // A result arriving in the timeout cycle takes priority over the timeout.
        if (bus.s00_axis_tvalid) begin
          w_state_next    = ST_DONE;
          w_result_next   = bus.s00_axis_tdata;
          w_error_next    = !bus.s00_axis_tlast;
          w_s_tready_next = 1'b0;
        end else if (w_timeout) begin
          w_state_next    = ST_DONE;
          w_error_next    = 1'b1;
          w_s_tready_next = 1'b0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state    <= ST_IDLE;
      r_tvalid   <= 1'b0;
      r_tdata    <= '0;
      r_tlast    <= 1'b0;
      r_s_tready <= 1'b0;
      r_error    <= 1'b0;
      r_result   <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_tvalid   <= w_tvalid_next;
      r_tdata    <= w_tdata_next;
      r_tlast    <= w_tlast_next;
      r_s_tready <= w_s_tready_next;
      r_error    <= w_error_next;
      r_result   <= w_result_next;
      r_idx      <= w_idx_next;
      r_cnt      <= w_cnt_next;
    end
  end

  assign bus.m00_axis_tvalid = r_tvalid;
  assign bus.m00_axis_tdata  = r_tdata;
  assign bus.m00_axis_tstrb  = '1;
  assign bus.m00_axis_tlast  = r_tlast;
  assign bus.s00_axis_tready = r_s_tready;
  assign bus.busy            = (r_state == ST_SEND) || (r_state == ST_WAIT);
  assign bus.done            = (r_state == ST_DONE);
  assign bus.error           = r_error;
  assign bus.result          = r_result;

endmodule

// File: tb/tb_fp_stream_source.sv
// Scoreboard bench for fp_stream_source: directed runs push expected beats and
// results into queues; a negedge monitor pops and compares as the DUT emits them.
module tb_fp_stream_source;

  localparam int SIZE    = 10;
  localparam int DW      = 32;
  localparam int AW      = 10;
  localparam int TIMEOUT = 16;

  localparam logic [31:0] VEC [SIZE] = '{
    32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
    32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000
  };

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [31:0] result;
    logic        error;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_stream_source_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fp_stream_source #(
    .SIZE(SIZE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TIMEOUT)
  ) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_aresetn(rst_n),
    .bus            (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t       exp_beats[$];
  res_t        exp_res[$];
  logic [31:0] mdl_buf [SIZE];

  int hs_count, first_hs_cyc, last_hs_cyc, wait_entry_cyc, done_cyc, n_done;
  int t_start;
  int tr_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic        prev_stall, prev_last, prev_s_tready, prev_done;
    logic [31:0] prev_data;
    beat_t       b;
    res_t        r;
    prev_stall = 1'b0; prev_last = 1'b0; prev_s_tready = 1'b0; prev_done = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_stall) begin
          check("stall_hold_valid", bus.m00_axis_tvalid, 1'b1);
          check("stall_hold_data",  bus.m00_axis_tdata,  prev_data);
          check("stall_hold_last",  bus.m00_axis_tlast,  prev_last);
        end
        if (bus.m00_axis_tvalid && bus.m00_axis_tready) begin
          check("beat_expected", exp_beats.size() != 0, 1'b1);
          if (exp_beats.size() != 0) begin
            b = exp_beats.pop_front();
            check("beat_data", bus.m00_axis_tdata, b.data);
            check("beat_last", bus.m00_axis_tlast, b.last);
          end
          if (hs_count == 0) first_hs_cyc = cyc;
          last_hs_cyc = cyc;
          hs_count++;
        end
        if (bus.s00_axis_tready && !prev_s_tready) wait_entry_cyc = cyc;
        if (bus.done && !prev_done) begin
          done_cyc = cyc;
          n_done++;
          check("res_expected", exp_res.size() != 0, 1'b1);
          if (exp_res.size() != 0) begin
            r = exp_res.pop_front();
            check("result_value", bus.result, r.result);
            check("result_error", bus.error, r.error);
          end
          check("busy_at_done",   bus.busy, 1'b0);
          check("s_tready_at_done", bus.s00_axis_tready, 1'b0);
        end
      end
      prev_stall    = rst_n && bus.m00_axis_tvalid && !bus.m00_axis_tready;
      prev_data     = bus.m00_axis_tdata;
      prev_last     = bus.m00_axis_tlast;
      prev_s_tready = bus.s00_axis_tready;
      prev_done     = bus.done;
    end
  end

  // ---------------- downstream ready driver ----------------
  initial begin
    bus.m00_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (tr_mode)
        0:       bus.m00_axis_tready = 1'b1;
        1:       bus.m00_axis_tready = ~bus.m00_axis_tready;
        default: bus.m00_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [31:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic start_run();
    for (int i = 0; i < SIZE; i++) exp_beats.push_back('{mdl_buf[i], i == SIZE - 1});
    hs_count  = 0;
    t_start   = cyc + 1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_s_ready();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.s00_axis_tready) begin ok = 1'b1; break; end
      tick();
    end
    check("wait_entry_reached", ok, 1'b1);
  endtask

  task automatic respond(input logic [31:0] d, input logic last, input int delay);
    wait_s_ready();
    repeat (delay) tick();
    bus.s00_axis_tvalid = 1'b1; bus.s00_axis_tdata = d; bus.s00_axis_tlast = last;
    tick();
    bus.s00_axis_tvalid = 1'b0; bus.s00_axis_tdata = '0; bus.s00_axis_tlast = 1'b0;
  endtask

  task automatic wait_done(input int target);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (n_done >= target) begin ok = 1'b1; break; end
      tick();
    end
    check("done_reached", ok, 1'b1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_tvalid"},   bus.m00_axis_tvalid, 1'b0);
    check({tag, "_tlast"},    bus.m00_axis_tlast,  1'b0);
    check({tag, "_tdata"},    bus.m00_axis_tdata,  32'h0);
    check({tag, "_s_tready"}, bus.s00_axis_tready, 1'b0);
    check({tag, "_busy"},     bus.busy,            1'b0);
    check({tag, "_done"},     bus.done,            1'b0);
    check({tag, "_error"},    bus.error,           1'b0);
    check({tag, "_result"},   bus.result,          32'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.start = 1'b0;
    bus.s00_axis_tvalid = 1'b0; bus.s00_axis_tdata = '0; bus.s00_axis_tlast = 1'b0;
    hs_count = 0; n_done = 0; wait_entry_cyc = 0; done_cyc = 0;
    first_hs_cyc = 0; last_hs_cyc = 0; t_start = 0;

    #23;
    check_reset("reset");
    check("tstrb_ones", bus.m00_axis_tstrb, 4'hF);
    @(negedge clk); #2 rst_n = 1'b1;
    tick();

    // Load 1.0 .. 10.0; out-of-range writes must not alias onto buf[0]/buf[1].
    for (int i = 0; i < SIZE; i++) begin
      write_word(AW'(i), VEC[i]);
      mdl_buf[i] = VEC[i];
    end
    write_word(10'd16, 32'hBAADF00D);
    write_word(10'd17, 32'hBAADF00D);

    // 1: full-rate packet, result 55.0 three cycles after the last beat.
    tr_mode = 0;
    n0 = n_done;
    exp_res.push_back('{32'h425C0000, 1'b0});
    start_run();
    check("busy_in_send", bus.busy, 1'b1);
    respond(32'h425C0000, 1'b1, 3);
    wait_done(n0 + 1);
    check("burst_beats",      hs_count,       SIZE);
    check("burst_first_cyc",  first_hs_cyc,   t_start);
    check("burst_last_cyc",   last_hs_cyc,    t_start + SIZE - 1);
    check("burst_wait_entry", wait_entry_cyc, t_start + SIZE);
    tick();
    check("done_level", bus.done, 1'b1);

    // 2: tready toggling, then pseudo-random.
    for (int m = 1; m <= 2; m++) begin
      tr_mode = m;
      n0 = n_done;
      exp_res.push_back('{32'h425C0000, 1'b0});
      start_run();
      respond(32'h425C0000, 1'b1, 0);
      wait_done(n0 + 1);
      check("stalled_beats", hs_count, SIZE);
    end
    tr_mode = 0;

    // 3: no response -> timeout after exactly TIMEOUT cycles, result kept.
    n0 = n_done;
    exp_res.push_back('{32'h425C0000, 1'b1});
    start_run();
    wait_done(n0 + 1);
    check("timeout_latency", done_cyc - wait_entry_cyc, TIMEOUT);

    // 4: result without tlast flags an error but is still latched.
    n0 = n_done;
    exp_res.push_back('{32'h40400000, 1'b1});
    start_run();
    check("error_cleared_on_start", bus.error, 1'b0);
    respond(32'h40400000, 1'b0, 2);
    wait_done(n0 + 1);

    // 5: write coinciding with start is dropped; write during SEND is ignored.
    n0 = n_done;
    exp_res.push_back('{32'h41200000, 1'b0});
    bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_data = 32'hDEADBEEF;
    start_run();
    bus.wr_addr = 10'd5; bus.wr_data = 32'hCAFEF00D;
    tick();
    bus.wr_en = 1'b0;
    respond(32'h41200000, 1'b1, 1);
    wait_done(n0 + 1);

    n0 = n_done;
    exp_res.push_back('{32'h41200000, 1'b0});
    start_run();
    respond(32'h41200000, 1'b1, 0);
    wait_done(n0 + 1);

    // A write in DONE is accepted and shows up in the next packet.
    write_word(10'd2, 32'h12345678);
    mdl_buf[2] = 32'h12345678;
    n0 = n_done;
    exp_res.push_back('{32'h3F800000, 1'b0});
    start_run();
    respond(32'h3F800000, 1'b1, 0);
    wait_done(n0 + 1);
    write_word(10'd2, VEC[2]);
    mdl_buf[2] = VEC[2];

    // 6: asynchronous reset while beat 4 is on the bus.
    start_run();
    for (int i = 0; i < 50 && hs_count < 5; i++) @(negedge clk);
    check("beat4_reached", hs_count, 5);
    #2 rst_n = 1'b0;
    #1;
    check_reset("midrun_reset");
    exp_beats.delete();
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b1;
    tick();

    n0 = n_done;
    exp_res.push_back('{32'h425C0000, 1'b0});
    start_run();
    respond(32'h425C0000, 1'b1, 0);
    wait_done(n0 + 1);
    check("post_reset_beats", hs_count, SIZE);

    repeat (3) tick();
    check("beats_left", exp_beats.size(), 0);
    check("results_left", exp_res.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
